arbitro_rr4: RTL



---
 rtl/arbitro_rr4.sv | 132 +++++++++++++
 1 files changed

// File: rtl/arbitro_rr4.sv
// Round-robin scheduler sharing one TX byte path among four lane FIFOs.
// Optional build macro PRIO_LANE0_EN makes lane 0 strict priority over lanes 1-3.
module arbitro_rr4 #(
   parameter int DATA_W   = 8,
   parameter int IDLE_CNT = 4
) (
   input  logic              clk_f,
   input  logic              reset,
   input  logic              active,
   input  logic [3:0]        empty_in,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   input  logic              almost_full_in,
   output logic [3:0]        pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        lane_sel,
   output logic              idle,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_RUN  = 2'd1,
      S_IDLE = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [1:0]        last_grant;
   logic [1:0]        rr_grant;
   logic [1:0]        grant;
   logic [1:0]        scan_idx;
   logic              rr_vld;
   logic              grant_vld;
   logic              lg_upd;
   logic              arb_en;
   logic [3:0]        req;
   logic [3:0]        idle_cnt, idle_cnt_next;
   logic [DATA_W-1:0] sel_data;

   assign state_dbg = state;

   // Arbitration: scan last_grant+1 .. last_grant+4 so the previous winner is checked last.
   always_comb begin
      arb_en   = ~reset & active & ((state == S_RUN) | (state == S_IDLE));
      req      = almost_full_in ? 4'b0000 : ~empty_in;
      rr_vld   = 1'b0;
      rr_grant = last_grant;
      scan_idx = last_grant;
      for (int k = 1; k <= 4; k++) begin
         scan_idx = last_grant + 2'(k);
         if (!rr_vld && req[scan_idx]) begin
            rr_vld   = 1'b1;
            rr_grant = scan_idx;
         end
      end
`ifdef PRIO_LANE0_EN
      // Lane 0 wins outright and leaves the round-robin pointer untouched.
      grant_vld = req[0] | rr_vld;
      grant     = req[0] ? 2'd0 : rr_grant;
      lg_upd    = arb_en & rr_vld & ~req[0];
`else
      grant_vld = rr_vld;
      grant     = rr_grant;
      lg_upd    = arb_en & rr_vld;
`endif
      pop = (arb_en && grant_vld) ? (4'b0001 << grant) : 4'b0000;
      case (grant)
         2'd0:    sel_data = data_in0;
         2'd1:    sel_data = data_in1;
         2'd2:    sel_data = data_in2;
         default: sel_data = data_in3;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         S_INIT: if (active) state_next = S_RUN;
         S_RUN: begin
            if (!active)
               state_next = S_INIT;
            else if (idle_cnt == 4'(IDLE_CNT) && pop == 4'b0000)
               state_next = S_IDLE;
         end
         S_IDLE: begin
            if (!active)
               state_next = S_INIT;
            else if (pop != 4'b0000)
               state_next = S_RUN;
         end
         default: state_next = S_INIT;
      endcase

      // Counter only lives while staying in RUN without a pop; otherwise it clears.
      idle_cnt_next = 4'd0;
      if (state == S_RUN && state_next == S_RUN && pop == 4'b0000) begin
         if (empty_in == 4'hF && idle_cnt != 4'(IDLE_CNT))
            idle_cnt_next = idle_cnt + 4'd1;
         else
            idle_cnt_next = idle_cnt;
      end
   end

   always_ff @(posedge clk_f) begin
      if (reset) begin
         state      <= S_INIT;
         last_grant <= 2'd3;
         idle_cnt   <= 4'd0;
         idle       <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         lane_sel   <= 2'd0;
      end else begin
         state    <= state_next;
         idle_cnt <= idle_cnt_next;
         idle     <= (state_next == S_IDLE);
         if (lg_upd)
            last_grant <= grant;
         if (pop != 4'b0000) begin
            data_out  <= sel_data;
            valid_out <= 1'b1;
            lane_sel  <= grant;
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule
